// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan controller.
// Segment codes are active-high; seg[0]=a ... seg[6]=g.
package sevenseg_pkg;

  typedef logic [6:0] seg7_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BLANK = ST_BLANK,
    DRIVE = ST_DRIVE
  } scan_state_t;

  localparam seg7_t HEX_TO_SEG7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sevenseg_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern.
// Output polarity is applied by the scan controller.
module hex_to_seg7
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_hex,
  output seg7_t      o_seg
);

  assign o_seg = HEX_TO_SEG7[i_hex];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a blanking interval per slot
// and a double-buffered load port that commits only at frame boundaries.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   mask_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int   CTR_W = $clog2(TICK_DIV);
  localparam int   IDX_W = $clog2(NUM_DIGITS);
  localparam logic POL   = (ACTIVE_LOW != 0);

  scan_state_t               r_state;
  logic [CTR_W-1:0]          r_slot_ctr;
  logic [IDX_W-1:0]          r_idx;
  logic [4*NUM_DIGITS-1:0]   r_stg_digits, r_act_digits;
  logic [NUM_DIGITS-1:0]     r_stg_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]     r_stg_mask, r_act_mask;
  logic                      r_pending;
  logic                      r_load_ready;
  logic [NUM_DIGITS-1:0]     r_an;
  logic [6:0]                r_seg;
  logic                      r_dp;
  logic                      r_frame_start;

  scan_state_t               w_nxt_state;
  logic [CTR_W-1:0]          w_nxt_ctr;
  logic [IDX_W-1:0]          w_nxt_idx;
  logic                      w_frame, w_xfer, w_commit, w_nxt_pending, w_drive;
  logic [4*NUM_DIGITS-1:0]   w_act_digits;
  logic [NUM_DIGITS-1:0]     w_act_dp, w_act_mask, w_an_lit;
  logic [3:0]                w_nibble;
  seg7_t                     w_seg_raw;

  // NOTE: every signal gets a default at the top of each always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ctr   = r_slot_ctr;
    w_nxt_idx   = r_idx;
    if (!en) begin
      w_nxt_state = IDLE;
      w_nxt_ctr   = '0;
      w_nxt_idx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_state = BLANK;
          w_nxt_ctr   = '0;
          w_nxt_idx   = '0;
        end
        BLANK: begin
          w_nxt_ctr = r_slot_ctr + 1'b1;
          if (r_slot_ctr == CTR_W'(BLANK_CYCLES - 1)) w_nxt_state = DRIVE;
        end
        DRIVE: begin
          if (r_slot_ctr == CTR_W'(TICK_DIV - 1)) begin
            w_nxt_state = BLANK;
            w_nxt_ctr   = '0;
            w_nxt_idx   = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
          end else begin
            w_nxt_ctr = r_slot_ctr + 1'b1;
          end
        end
        default: begin
          w_nxt_state = IDLE;
          w_nxt_ctr   = '0;
          w_nxt_idx   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    w_frame  = (w_nxt_state == BLANK) && (w_nxt_ctr == '0) && (w_nxt_idx == '0);
    w_xfer   = load_valid && r_load_ready;
    w_commit = w_frame && r_pending;

    w_nxt_pending = r_pending;
    if (w_xfer)   w_nxt_pending = 1'b1;
    if (w_commit) w_nxt_pending = 1'b0;

    w_act_digits = w_commit ? r_stg_digits : r_act_digits;
    w_act_dp     = w_commit ? r_stg_dp     : r_act_dp;
    w_act_mask   = w_commit ? r_stg_mask   : r_act_mask;

    w_nibble = w_act_digits[{w_nxt_idx, 2'b00} +: 4];
    w_drive  = (w_nxt_state == DRIVE);

    w_an_lit = '0;
    if (w_drive && w_act_mask[w_nxt_idx]) w_an_lit[w_nxt_idx] = 1'b1;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_hex (w_nibble),
    .o_seg (w_seg_raw)
  );

  // NOTE: staging and active buffers are ordinary flops, not a RAM, and are reset
  // so that a reset mid-frame discards both the shown data and any pending update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_slot_ctr    <= '0;
      r_idx         <= '0;
      r_stg_digits  <= '0;
      r_stg_dp      <= '0;
      r_stg_mask    <= '0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
      r_act_mask    <= '0;
      r_pending     <= 1'b0;
      r_load_ready  <= 1'b1;
      r_an          <= {NUM_DIGITS{POL}};
      r_seg         <= {7{POL}};
      r_dp          <= POL;
      r_frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state      <= w_nxt_state;
      r_slot_ctr   <= w_nxt_ctr;
      r_idx        <= w_nxt_idx;
      if (w_xfer) begin
        r_stg_digits <= digits_in;
        r_stg_dp     <= dp_in;
        r_stg_mask   <= mask_in;
      end
      r_pending     <= w_nxt_pending;
      r_load_ready  <= !w_nxt_pending;
      r_act_digits  <= w_act_digits;
      r_act_dp      <= w_act_dp;
      r_act_mask    <= w_act_mask;
      r_an          <= w_an_lit ^ {NUM_DIGITS{POL}};
      r_seg         <= w_drive ? (w_seg_raw ^ {7{POL}}) : {7{POL}};
      r_dp          <= (w_drive && w_act_dp[w_nxt_idx]) ^ POL;
      r_frame_start <= w_frame;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;
  assign load_ready  = r_load_ready;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with a short slot (TICK_DIV=10, BLANK_CYCLES=2).
// Outputs are sampled on the falling edge; inputs change there too.
module tb_sevenseg_scan_ctrl;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [12:0] IDLE_VEC = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset, en, load_valid, load_ready;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, mask_in, an;
  logic [6:0]  seg;
  logic        dp, frame_start;
  logic [12:0] obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .TICK_DIV     (10),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .mask_in     (mask_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  assign obs = {an, seg, dp, frame_start};

  // Expected {an, seg, dp, frame_start} for cycle c counted from a frame_start.
  function automatic logic [12:0] exp_vec(input logic [15:0] d, input logic [3:0] m,
                                          input logic [3:0] p, input int c);
    int slot, off;
    logic [3:0] an_e, nib;
    logic [6:0] seg_e;
    logic       dp_e;
    slot  = (c / 10) % 4;
    off   = c % 10;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if (off >= 2) begin
      nib   = d[slot*4 +: 4];
      seg_e = ~SEG_TBL[nib];
      dp_e  = ~p[slot];
      if (m[slot]) an_e[slot] = 1'b0;
    end
    return {an_e, seg_e, dp_e, (c % 40) == 0};
  endfunction

  task automatic wait_frame(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (frame_start !== 1'b1 && lat < 60);
  endtask

  task automatic check_latency(input string name, input int lat);
    vectors++;
    if (lat != 1 || frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: frame_start after %0d cycles, required 1", name, lat);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] m, input logic [3:0] p);
    load_valid = 1'b1;
    digits_in  = d;
    mask_in    = m;
    dp_in      = p;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({obs, load_ready} !== {IDLE_VEC, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_hold: {an,seg,dp,fs,rdy} got %h required %h", {obs, load_ready}, {IDLE_VEC, 1'b1});
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({obs, load_ready} !== {IDLE_VEC, 1'b1}) begin
        miscompares++;
        $display("FAIL idle_after_reset i=%0d: got %h required %h", i, {obs, load_ready}, {IDLE_VEC, 1'b1});
      end
    end
  endtask

  task automatic test_scan;
    int lat;
    logic [13:0] e;
    load(16'h3210, 4'hF, 4'b0101);
    @(negedge clk);
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL scan_ready_drop: load_ready got %b required 0", load_ready);
    end
    load_valid = 1'b0;
    en = 1'b1;
    wait_frame(lat);
    check_latency("scan_frame_start", lat);
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      e = {exp_vec(16'h3210, 4'hF, 4'b0101, c), 1'b1};
      vectors++;
      if ({obs, load_ready} !== e) begin
        miscompares++;
        $display("FAIL scan c=%0d: {an,seg,dp,fs,rdy} got %h required %h", c, {obs, load_ready}, e);
      end
    end
  endtask

  task automatic test_mask;
    int lat;
    logic [13:0] e;
    wait_frame(lat);
    check_latency("mask_frame_start", lat);
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 40) e = {exp_vec(16'h3210, 4'hF, 4'b0101, c), !(c >= 6)};
      else        e = {exp_vec(16'h3210, 4'b1011, 4'b0000, c), 1'b1};
      vectors++;
      if ({obs, load_ready} !== e) begin
        miscompares++;
        $display("FAIL mask c=%0d: got %h required %h", c, {obs, load_ready}, e);
      end
      if (c == 5) load(16'h3210, 4'b1011, 4'b0000);
      if (c == 6) load_valid = 1'b0;
    end
  endtask

  task automatic test_midframe_load;
    int lat;
    logic [13:0] e;
    wait_frame(lat);
    check_latency("midframe_frame_start", lat);
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 40) e = {exp_vec(16'h3210, 4'b1011, 4'b0000, c), !(c >= 16)};
      else        e = {exp_vec(16'hABCD, 4'hF, 4'b0000, c), 1'b1};
      vectors++;
      if ({obs, load_ready} !== e) begin
        miscompares++;
        $display("FAIL midframe c=%0d: got %h required %h", c, {obs, load_ready}, e);
      end
      if (c == 15) load(16'hABCD, 4'hF, 4'b0000);
      if (c == 16) load(16'h5555, 4'hF, 4'hF);
      if (c == 20) load_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [13:0] e;
    wait_frame(lat);
    check_latency("boundary_frame_start", lat);
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 40) e = {exp_vec(16'hABCD, 4'hF, 4'b0000, c), (c == 0)};
      else        e = {exp_vec(16'h4567, 4'hF, 4'b0000, c), 1'b1};
      vectors++;
      if ({obs, load_ready} !== e) begin
        miscompares++;
        $display("FAIL boundary_xfer c=%0d: got %h required %h", c, {obs, load_ready}, e);
      end
      if (c == 0) load(16'h4567, 4'hF, 4'b0000);
      if (c == 1) load_valid = 1'b0;
    end
  endtask

  task automatic test_en_drop;
    int lat;
    logic [13:0] e;
    wait_frame(lat);
    check_latency("endrop_frame_start", lat);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      e = {exp_vec(16'h4567, 4'hF, 4'b0000, c), !(c >= 13)};
      vectors++;
      if ({obs, load_ready} !== e) begin
        miscompares++;
        $display("FAIL endrop_pre c=%0d: got %h required %h", c, {obs, load_ready}, e);
      end
      if (c == 12) load(16'h89AB, 4'hF, 4'b1000);
      if (c == 13) load_valid = 1'b0;
      if (c == 14) en = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if ({obs, load_ready} !== {IDLE_VEC, 1'b0}) begin
        miscompares++;
        $display("FAIL endrop_idle i=%0d: got %h required %h", i, {obs, load_ready}, {IDLE_VEC, 1'b0});
      end
    end
    en = 1'b1;
    wait_frame(lat);
    check_latency("endrop_restart", lat);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      e = {exp_vec(16'h89AB, 4'hF, 4'b1000, c), 1'b1};
      vectors++;
      if ({obs, load_ready} !== e) begin
        miscompares++;
        $display("FAIL endrop_post c=%0d: got %h required %h", c, {obs, load_ready}, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [13:0] e;
    wait_frame(lat);
    check_latency("rstmid_frame_start", lat);
    for (int c = 0; c < 26; c++) begin
      if (c > 0) @(negedge clk);
      e = {exp_vec(16'h89AB, 4'hF, 4'b1000, c), !(c >= 25)};
      vectors++;
      if ({obs, load_ready} !== e) begin
        miscompares++;
        $display("FAIL rstmid_pre c=%0d: got %h required %h", c, {obs, load_ready}, e);
      end
      if (c == 24) load(16'hFFFF, 4'hF, 4'hF);
    end
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if ({obs, load_ready} !== {IDLE_VEC, 1'b1}) begin
      miscompares++;
      $display("FAIL rstmid_async: got %h required %h", {obs, load_ready}, {IDLE_VEC, 1'b1});
    end
    @(negedge clk);
    vectors++;
    if ({obs, load_ready} !== {IDLE_VEC, 1'b1}) begin
      miscompares++;
      $display("FAIL rstmid_held: got %h required %h", {obs, load_ready}, {IDLE_VEC, 1'b1});
    end
    reset = 1'b0;
    wait_frame(lat);
    check_latency("rstmid_restart", lat);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      e = {exp_vec(16'h0000, 4'h0, 4'h0, c), 1'b1};
      vectors++;
      if ({obs, load_ready} !== e) begin
        miscompares++;
        $display("FAIL rstmid_post c=%0d: got %h required %h", c, {obs, load_ready}, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    load_valid = 1'b0;
    digits_in  = '0;
    dp_in      = '0;
    mask_in    = '0;
    test_reset();
    test_scan();
    test_mask();
    test_midframe_load();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
